// File: rtl/pwm_pkg.sv
// Shared constants and decoder state type for the PWM generator/decoder pair.
// Both ends of the loopback link take their defaults from here.
package pwm_pkg;

  localparam int PWM_SAMPLE_W = 8;
  localparam int PWM_PERIOD   = 256;
  localparam int PWM_TOL      = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    FLAT    = 2'd2
  } pwm_dec_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for an asynchronous pin, with rising-edge detect on
// the synchronized level. Shared with the UART RX path.
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic s,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic sync_d_r;

  // metastability stages plus one cycle of history for the edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
    end else begin
      meta_r   <= pin;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
    end
  end

  assign s    = sync_r;
  assign rise = sync_r & ~sync_d_r;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers the per-period duty value of a PWM input as a saturated sample,
// with period tolerance checking and a flat-level (0%/100%) fallback.
module pwm_sample_decoder
  import pwm_pkg::*;
#(
  parameter int SAMPLE_W = PWM_SAMPLE_W,
  parameter int PERIOD   = PWM_PERIOD,
  parameter int TOL      = PWM_TOL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                err_period
);

  localparam int CNT_W = $clog2(PERIOD + TOL + 2);

  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    PER_NOM    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]    PER_MIN    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0]    PER_MAX    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]    PER_TMO    = CNT_W'(PERIOD + TOL + 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = {SAMPLE_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = {SAMPLE_W{1'b0}};
  localparam logic [CNT_W-1:0]    SAT_LIMIT  = {{(CNT_W-SAMPLE_W){1'b0}}, SAMPLE_MAX};

  logic s_s;
  logic rise_s;

  pwm_in_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (pwm_in),
    .s    (s_s),
    .rise (rise_s)
  );

  pwm_dec_state_t      state_r,  state_nx_s;
  logic [CNT_W-1:0]    per_cnt_r, per_cnt_nx_s;
  logic [CNT_W-1:0]    hi_cnt_r,  hi_cnt_nx_s;
  logic [SAMPLE_W-1:0] sample_r,  sample_nx_s;
  logic                valid_r,   valid_nx_s;
  logic                locked_r,  locked_nx_s;
  logic                err_r,     err_nx_s;
  logic                period_ok_s;
  logic [SAMPLE_W-1:0] sat_hi_s;

  // period acceptance window and saturated high-time for the current measurement
  always_comb begin
    period_ok_s = (per_cnt_r >= PER_MIN) && (per_cnt_r <= PER_MAX);
    if (hi_cnt_r > SAT_LIMIT) begin
      sat_hi_s = SAMPLE_MAX;
    end else begin
      sat_hi_s = hi_cnt_r[SAMPLE_W-1:0];
    end
  end

  // next-state, counter and output decisions; a rise always beats the timeout
  always_comb begin
    state_nx_s   = state_r;
    per_cnt_nx_s = per_cnt_r;
    hi_cnt_nx_s  = hi_cnt_r;
    sample_nx_s  = sample_r;
    valid_nx_s   = 1'b0;
    err_nx_s     = 1'b0;
    locked_nx_s  = locked_r;
    if (!ena) begin
      state_nx_s   = SEARCH;
      per_cnt_nx_s = CNT_ZERO;
      hi_cnt_nx_s  = CNT_ZERO;
      locked_nx_s  = 1'b0;
    end else begin
      case (state_r)
        SEARCH: begin
          if (rise_s) begin
            state_nx_s   = MEASURE;
            per_cnt_nx_s = CNT_ONE;
            hi_cnt_nx_s  = CNT_ONE;
          end else begin
            per_cnt_nx_s = CNT_ZERO;
            hi_cnt_nx_s  = CNT_ZERO;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            per_cnt_nx_s = CNT_ONE;
            hi_cnt_nx_s  = CNT_ONE;
            if (period_ok_s) begin
              sample_nx_s = sat_hi_s;
              valid_nx_s  = 1'b1;
              locked_nx_s = 1'b1;
            end else begin
              err_nx_s    = 1'b1;
              locked_nx_s = 1'b0;
            end
          end else if (per_cnt_r == PER_TMO) begin
            // no edge for too long: the input is parked at a rail
            state_nx_s   = FLAT;
            per_cnt_nx_s = CNT_ONE;
            hi_cnt_nx_s  = CNT_ZERO;
            sample_nx_s  = s_s ? SAMPLE_MAX : SAMPLE_MIN;
            valid_nx_s   = 1'b1;
          end else begin
            per_cnt_nx_s = per_cnt_r + CNT_ONE;
            hi_cnt_nx_s  = hi_cnt_r + {{(CNT_W-1){1'b0}}, s_s};
          end
        end
        FLAT: begin
          if (rise_s) begin
            state_nx_s   = MEASURE;
            per_cnt_nx_s = CNT_ONE;
            hi_cnt_nx_s  = CNT_ONE;
          end else if (per_cnt_r == PER_NOM) begin
            per_cnt_nx_s = CNT_ONE;
            valid_nx_s   = 1'b1;
          end else begin
            per_cnt_nx_s = per_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx_s   = SEARCH;
          per_cnt_nx_s = CNT_ZERO;
          hi_cnt_nx_s  = CNT_ZERO;
          locked_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= SEARCH;
      per_cnt_r <= CNT_ZERO;
      hi_cnt_r  <= CNT_ZERO;
      sample_r  <= SAMPLE_MIN;
      valid_r   <= 1'b0;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      per_cnt_r <= per_cnt_nx_s;
      hi_cnt_r  <= hi_cnt_nx_s;
      sample_r  <= sample_nx_s;
      valid_r   <= valid_nx_s;
      locked_r  <= locked_nx_s;
      err_r     <= err_nx_s;
    end
  end

  assign sample       = sample_r;
  assign sample_valid = valid_r;
  assign locked       = locked_r;
  assign err_period   = err_r;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Bench for pwm_sample_decoder: directed scenarios plus random PWM traffic,
// compared every cycle against a timestamp-based reference model.
module tb_pwm_sample_decoder;

  localparam int SW  = 8;
  localparam int PER = 256;
  localparam int TOL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          pwm_in = 1'b0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          locked;
  logic          err_period;

  pwm_sample_decoder #(.SAMPLE_W(SW), .PERIOD(PER), .TOL(TOL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .locked      (locked),
    .err_period  (err_period)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_valid = 0;
  int obs_err = 0;

  // reference model: synchronized level history indexed by edge number
  bit            lvl [100000];
  int            k = 0;
  bit            m_meta = 1'b0, m_sync = 1'b0, m_syncd = 1'b0;
  int            mode = 0;          // 0 idle, 1 tracking periods, 2 flat level
  int            t0 = 0, tf = 0;    // edge of last accepted-or-rejected rise, of flat entry
  logic [SW-1:0] e_sample = '0;
  bit            e_valid = 1'b0, e_locked = 1'b0, e_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input bit p, input bit en, input bit rn);
    bit s, rise;
    int per, hi;
    pwm_in = p;
    ena    = en;
    rst_n  = rn;
    @(posedge clk);
    k++;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!rn) begin
      m_meta = 1'b0; m_sync = 1'b0; m_syncd = 1'b0;
      mode = 0; e_sample = '0; e_locked = 1'b0;
    end else begin
      s    = m_sync;
      rise = m_sync & ~m_syncd;
      lvl[k] = s;
      m_syncd = m_sync; m_sync = m_meta; m_meta = p;
      if (!en) begin
        mode = 0;
        e_locked = 1'b0;
      end else if (mode == 0) begin
        if (rise) begin mode = 1; t0 = k; end
      end else if (mode == 1) begin
        if (rise) begin
          per = k - t0;
          hi = 0;
          for (int j = t0; j < k; j++) hi += int'(lvl[j]);
          if (per >= PER - TOL && per <= PER + TOL) begin
            e_sample = (hi > 255) ? 8'd255 : 8'(hi);
            e_valid  = 1'b1;
            e_locked = 1'b1;
          end else begin
            e_err    = 1'b1;
            e_locked = 1'b0;
          end
          t0 = k;
        end else if (k - t0 == PER + TOL + 1) begin
          mode = 2; tf = k;
          e_sample = s ? 8'hFF : 8'h00;
          e_valid  = 1'b1;
        end
      end else begin
        if (rise) begin mode = 1; t0 = k; end
        else if ((k - tf) % PER == 0) e_valid = 1'b1;
      end
    end
    #1;
    if (sample_valid) obs_valid++;
    if (err_period) obs_err++;
    check_val("outs", {sample, sample_valid, locked, err_period},
              {e_sample, e_valid, e_locked, e_err});
  endtask

  task automatic hold(input bit p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b1, 1'b1);
  endtask

  task automatic period(input int len, input int hi, input bit en);
    for (int i = 0; i < len; i++) step(i < hi, en, 1'b1);
  endtask

  int len, hi;

  initial begin
    // reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_val("reset_outs", {sample, sample_valid, locked, err_period}, 32'd0);

    // constant low from reset: never leaves search
    obs_valid = 0;
    hold(1'b0, 1000);
    check_val("search_no_valid", obs_valid, 32'd0);
    check_val("search_locked", locked, 32'd0);

    // duty 64: one sample per period from the second rise on
    obs_valid = 0;
    for (int i = 0; i < 5; i++) period(256, 64, 1'b1);
    check_val("duty64_valids", obs_valid, 32'd4);
    check_val("duty64_sample", sample, 32'd64);
    check_val("duty64_locked", locked, 32'd1);

    // lock at 128 then park high: flat at 255 every PERIOD
    for (int i = 0; i < 2; i++) period(256, 128, 1'b1);
    obs_valid = 0;
    hold(1'b1, 800);
    check_val("flat_valids", obs_valid, 32'd4);
    check_val("flat_sample", sample, 32'd255);
    check_val("flat_locked", locked, 32'd1);
    obs_valid = 0;
    hold(1'b0, 50);
    for (int i = 0; i < 3; i++) period(256, 100, 1'b1);
    check_val("flat_exit_valids", obs_valid, 32'd2);
    check_val("flat_exit_sample", sample, 32'd100);

    // tolerance edges: 252/260 accepted, 251/261 rejected
    obs_valid = 0;
    obs_err = 0;
    period(252, 90, 1'b1);
    period(260, 90, 1'b1);
    period(251, 90, 1'b1);
    period(256, 90, 1'b1);
    period(261, 90, 1'b1);
    period(256, 90, 1'b1);
    period(256, 90, 1'b1);
    check_val("tol_valids", obs_valid, 32'd5);
    check_val("tol_errs", obs_err, 32'd2);
    check_val("tol_sample", sample, 32'd90);

    // enable drop mid-period while locked at 200
    for (int i = 0; i < 4; i++) period(256, 200, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_val("ena_locked", locked, 32'd0);
    check_val("ena_valid", sample_valid, 32'd0);
    for (int i = 101; i < 256; i++) step(i < 200, 1'b0, 1'b1);
    period(256, 200, 1'b0);
    obs_valid = 0;
    for (int i = 0; i < 3; i++) period(256, 200, 1'b1);
    check_val("ena_resume_valids", obs_valid, 32'd2);
    check_val("ena_resume_sample", sample, 32'd200);

    // one-cycle reset mid-period
    for (int i = 0; i < 2; i++) period(256, 120, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check_val("rst_outs", {sample, sample_valid, locked, err_period}, 32'd0);
    obs_valid = 0;
    hold(1'b0, 100);
    for (int i = 0; i < 3; i++) period(256, 120, 1'b1);
    check_val("rst_resume_valids", obs_valid, 32'd2);
    check_val("rst_resume_sample", sample, 32'd120);

    // random traffic: jittered periods, odd duties, rails and enable drops
    for (int n = 0; n < 60; n++) begin
      len = int'($urandom_range(244, 268));
      hi  = int'($urandom_range(0, len - 1));
      case ($urandom_range(0, 9))
        0:       period(len, 0, 1'b1);
        1:       period(600, 600, 1'b1);
        2:       period(len, hi, 1'b0);
        default: period(len, hi, 1'b1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_sample_decoder.md
# pwm_sample_decoder

Receive-side counterpart of the PWM sine generator: takes a PWM waveform on an input pin and recovers the per-period duty value as an 8-bit sample. It sits beside the generator in the Tiny Tapeout top. In loopback it checks the generator's `uo_out[2]` output via a `ui_in` pin. It produces a stream of recovered samples that can be compared against the sine table or forwarded to the UART transmitter.

## Interface

Parameters:
- `SAMPLE_W`, 8: width of the recovered sample.
- `PERIOD`, 256: nominal PWM period in clocks. Must be at least `2**SAMPLE_W`.
- `TOL`, 4: accepted deviation of a measured period from `PERIOD`, in clocks.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: synchronous, active-low reset.
- `ena`, in, 1: block enable. When low, the block is forced to SEARCH.
- `pwm_in`, in, 1: asynchronous PWM input.
- `sample`, out, `SAMPLE_W`: last recovered duty value.
- `sample_valid`, out, 1: one-cycle pulse when `sample` updates.
- `locked`, out, 1: high while valid periods or flat levels are being tracked.
- `err_period`, out, 1: one-cycle pulse on a rejected period.

## Operation

Input conditioning:
- `pwm_in` passes through a 2-flop synchronizer to give `s`; `s_d` is `s` delayed one cycle.
- `rise = s & ~s_d`.

Counters:
- `per_cnt` and `hi_cnt` are each `$clog2(PERIOD+TOL+2)` bits wide.
- Both are unsigned and never wrap.

States:
- SEARCH:
  - Counters idle.
  - On `rise`, load `per_cnt=1` and `hi_cnt=1`, then go to MEASURE.
- MEASURE:
  - Each cycle without `rise`: `per_cnt++`, and `hi_cnt += s`.
  - On `rise`, accept the period if `|per_cnt - PERIOD| <= TOL`:
    - `sample = min(hi_cnt, 2**SAMPLE_W-1)`.
    - Pulse `sample_valid`; set `locked=1`.
  - On `rise` with the period out of tolerance:
    - Pulse `err_period`; set `locked=0`; `sample` holds.
  - In both cases, reload the counters to 1 and stay in MEASURE.
  - Timeout: when `per_cnt == PERIOD+TOL+1` with no `rise`, go to FLAT.
- FLAT (0% or 100% duty, no edges):
  - On the timeout entry cycle, `sample = s ? 2**SAMPLE_W-1 : 0` and `sample_valid` pulses.
  - Then re-emit the same level every `PERIOD` clocks.
  - `locked` holds its previous value.
  - On `rise`, load the counters to 1 and go to MEASURE.

Boundary conditions:
- Constant level from reset: stays in SEARCH; no `sample_valid`.
- `rise` on the same cycle as a timeout: `rise` wins and the timeout is ignored.
- `ena=0`: next state SEARCH; `locked`, `sample_valid` and `err_period` go to 0; `sample` holds; the synchronizer keeps running.
- `rst_n=0` mid-period: everything clears on the next edge; no partial-period sample is ever emitted.

## Timing

- Reset values:
  - `sample=0`, `sample_valid=0`, `locked=0`, `err_period=0`.
  - State SEARCH; synchronizer flops 0; counters 0.
- All outputs are registered.
- Latency: `pwm_in` rising at pin edge t gives `rise` at t+2, and `sample_valid`/`err_period` at t+3.
- The first valid sample appears after two rising edges.
- Duty resolution: one clock per LSB. A high time of N clocks yields `sample=N`, with the `rise` cycle counted as high.
- Synchronizer delay is equal on both edges, so it does not bias `hi_cnt`.
- Accepted period range: `PERIOD-TOL` to `PERIOD+TOL` inclusive.

## Structure

- Shared package `pwm_pkg`:
  - State enum `pwm_dec_state_t` (SEARCH, MEASURE, FLAT).
  - Default `PERIOD`, `SAMPLE_W` and `TOL` constants, shared with the generator.
- Sub-module `pwm_in_sync`:
  - 2-flop synchronizer plus rise detect.
  - Outputs `s` and `rise`.
  - Reusable for the UART RX pin.
- Top-level `pwm_sample_decoder`: FSM, counters and output registers.

## Test plan

1. Duty 64/256 repeated 4 periods → `sample=64` with `sample_valid` once per period, starting after the 2nd rise; `locked=1` from then on.
2. Lock at duty 128, then hold `pwm_in` high → FLAT entered at `per_cnt=261`, `sample=255` with valid, repeating every 256 clocks; next rise returns to MEASURE.
3. Tolerance edges → period 252 and 260 accepted; 251 and 261 raise `err_period`, set `locked=0`, and leave `sample` unchanged.
4. Constant low from reset for 1000 clocks → no `sample_valid`, `locked=0`, state SEARCH.
5. Drop `ena` mid-period while locked at duty 200 → `locked=0` next cycle, no valid; after re-enable, first `sample=200` arrives after two rises.
6. Assert `rst_n=0` for 1 cycle mid-period → all outputs 0 next cycle; no stale sample after release.
